// File: rtl/cam_pixel_axis_packer_pkg.sv
// Shared definitions for the camera pixel packer and its beat FIFO.
//   PIX_W / LANES   : pixel width and pixel lanes per 32-bit beat
//   state_t         : packer FSM states (RUN packs pixels, DROP discards until frame start)
//   entry_t         : FIFO entry layout {user, last, strb, data}
//   lane_mask()     : valid-lane mask for a word whose highest written lane is 'top'
package cam_pixel_axis_packer_pkg;

  localparam int PIX_W   = 8;
  localparam int LANES   = 4;
  localparam int DATA_W  = PIX_W * LANES;
  localparam int ENTRY_W = 1 + 1 + LANES + DATA_W;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  typedef struct packed {
    logic              user;
    logic              last;
    logic [LANES-1:0]  strb;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] top);
    logic [LANES-1:0] m;
    case (top)
      2'd0:    m = 4'h1;
      2'd1:    m = 4'h3;
      2'd2:    m = 4'h7;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cam_pixel_axis_packer_axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst        : clock, synchronous active-high reset (clears pointers)
//   push, wr_data   : write request; accepted when !full or when pop is also high
//   pop             : read request; ignored while empty
//   rd_data         : head entry, forced to zero while empty
//   full, empty     : status, resolved by the extra pointer MSB
module axis_sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cam_pixel_axis_packer.sv
// Camera pixel packer: packs four 8-bit pixels per 32-bit beat, buffers beats
// in a FWFT FIFO and drives them as an AXI4-Stream master.
//   M_AXIS_ACLK / M_AXIS_ARESET : clock, synchronous active-high reset
//   pix_valid/pix_data/pix_sof/pix_eol : pixel input with frame/line markers
//   ovf_clr        : clears ovf_sticky
//   M_AXIS_T*      : AXI4-Stream master (TLAST = end of line, TUSER = start of frame)
//   ovf_sticky     : a beat was lost because the FIFO was full
//   sof_err_cnt    : saturating count of frame starts that cut a partial word
//   frame_cnt      : handshaked TUSER beats, wrapping
module cam_pixel_axis_packer
  import cam_pixel_axis_packer_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESET,
  input  logic                              pix_valid,
  input  logic [7:0]                        pix_data,
  input  logic                              pix_sof,
  input  logic                              pix_eol,
  input  logic                              ovf_clr,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TUSER,
  output logic                              ovf_sticky,
  output logic [7:0]                        sof_err_cnt,
  output logic [15:0]                       frame_cnt
);

  state_t     state_q, state_d;
  logic [1:0] cnt_q;
  logic [7:0] lane_q [3];
  logic       user_q;
  logic       word_vld_q;
  entry_t     word_q;

  logic       ovf_q;
  logic [7:0] sof_err_q;
  logic [15:0] frame_q;

  logic       fifo_full, fifo_empty, pop;
  entry_t     head;

  logic       refused, accept, complete, sof_err_inc;
  logic [1:0] eff_cnt;
  entry_t     word_d;

  // Completed words sit one cycle in word_q before entering the FIFO.
  axis_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (M_AXIS_ACLK),
    .rst     (M_AXIS_ARESET),
    .push    (word_vld_q),
    .wr_data (word_q),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop = !fifo_empty && M_AXIS_TREADY;

  always_comb begin
    state_d     = state_q;
    refused     = word_vld_q && fifo_full && !pop;
    // A refused push also throws away the pixel of that cycle.
    accept      = pix_valid && !refused && ((state_q == ST_RUN) || pix_sof);
    eff_cnt     = pix_sof ? 2'd0 : cnt_q;
    sof_err_inc = accept && pix_sof && (cnt_q != 2'd0);
    complete    = accept && ((eff_cnt == 2'd3) || pix_eol);

    word_d      = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (2'(i) < eff_cnt) word_d.data[i*8 +: 8] = lane_q[i];
    end
    word_d.data[{eff_cnt, 3'b000} +: 8] = pix_data;
    word_d.strb = lane_mask(eff_cnt);
    word_d.last = pix_eol;
    word_d.user = (eff_cnt == 2'd0) ? pix_sof : user_q;

    if (refused) begin
      state_d = ST_DROP;
    end else if ((state_q == ST_DROP) && pix_valid && pix_sof) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      user_q     <= 1'b0;
      word_vld_q <= 1'b0;
      word_q     <= '0;
      ovf_q      <= 1'b0;
      sof_err_q  <= '0;
      frame_q    <= '0;
      for (int unsigned i = 0; i < 3; i++) lane_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      word_vld_q <= complete;
      if (complete) word_q <= word_d;

      if (refused || (state_q == ST_DROP && !accept)) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= complete ? 2'd0 : eff_cnt + 2'd1;
        if (eff_cnt == 2'd0) user_q <= pix_sof;
        for (int unsigned i = 0; i < 3; i++) begin
          if (eff_cnt == 2'(i)) lane_q[i] <= pix_data;
        end
      end

      if (refused)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;

      if (sof_err_inc && (sof_err_q != 8'hFF)) sof_err_q <= sof_err_q + 8'd1;

      if (pop && head.user) frame_q <= frame_q + 16'd1;
    end
  end

  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TDATA  = head.data;
  assign M_AXIS_TSTRB  = head.strb;
  assign M_AXIS_TLAST  = head.last;
  assign M_AXIS_TUSER  = head.user;
  assign ovf_sticky    = ovf_q;
  assign sof_err_cnt   = sof_err_q;
  assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_cam_pixel_axis_packer.sv
module tb_cam_pixel_axis_packer;

  logic        M_AXIS_ACLK = 1'b0;
  logic        M_AXIS_ARESET;
  logic        pix_valid, pix_sof, pix_eol, ovf_clr;
  logic [7:0]  pix_data;
  logic        M_AXIS_TVALID, M_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TSTRB;
  logic        M_AXIS_TLAST, M_AXIS_TUSER;
  logic        ovf_sticky;
  logic [7:0]  sof_err_cnt;
  logic [15:0] frame_cnt;

  int checks = 0;
  int passed = 0;
  logic [37:0] beats [$];

  cam_pixel_axis_packer #(
    .C_M_AXIS_TDATA_WIDTH (32),
    .FIFO_DEPTH           (16)
  ) dut (
    .M_AXIS_ACLK   (M_AXIS_ACLK),
    .M_AXIS_ARESET (M_AXIS_ARESET),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .ovf_clr       (ovf_clr),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .ovf_sticky    (ovf_sticky),
    .sof_err_cnt   (sof_err_cnt),
    .frame_cnt     (frame_cnt)
  );

  always #5 M_AXIS_ACLK = ~M_AXIS_ACLK;

  // Inputs change 1ns after posedge, so negedge values are what the next edge samples.
  always @(negedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESET && M_AXIS_TVALID && M_AXIS_TREADY)
      beats.push_back({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TDATA});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic u, input logic l,
                          input logic [3:0] s, input logic [31:0] d);
    logic [37:0] obs;
    obs = (idx < beats.size()) ? beats[idx] : 'x;
    chk(tag, 64'(obs), 64'({u, l, s, d}));
  endtask

  task automatic step();
    @(posedge M_AXIS_ACLK);
    #1;
  endtask

  task automatic pix(input logic [7:0] d, input logic sof, input logic eol);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    pix_eol   = eol;
    step();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    M_AXIS_ARESET = 1'b1;
    M_AXIS_TREADY = 1'b0;
    pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; pix_eol = 1'b0; ovf_clr = 1'b0;
    idle(3);
    M_AXIS_ARESET = 1'b0;
    idle(1);

    // Reset state
    chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_payload", 64'({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TDATA}), 64'd0);
    chk("rst_ovf", 64'(ovf_sticky), 64'd0);
    chk("rst_soferr", 64'(sof_err_cnt), 64'd0);
    chk("rst_frames", 64'(frame_cnt), 64'd0);

    // 8-pixel line with frame start
    M_AXIS_TREADY = 1'b1;
    for (int i = 1; i <= 8; i++) pix(8'(i), i == 1, i == 8);
    idle(5);
    chk("l8_count", 64'(beats.size()), 64'd2);
    chk_beat("l8_b0", 0, 1'b1, 1'b0, 4'hF, 32'h04030201);
    chk_beat("l8_b1", 1, 1'b0, 1'b1, 4'hF, 32'h08070605);
    chk("l8_frames", 64'(frame_cnt), 64'd1);

    // 6-pixel line: short final beat
    beats.delete();
    for (int i = 1; i <= 6; i++) pix(8'(i), 1'b0, i == 6);
    idle(5);
    chk("l6_count", 64'(beats.size()), 64'd2);
    chk_beat("l6_b0", 0, 1'b0, 1'b0, 4'hF, 32'h04030201);
    chk_beat("l6_b1", 1, 1'b0, 1'b1, 4'h3, 32'h00000605);
    chk("l6_frames", 64'(frame_cnt), 64'd1);

    // Frame start after two pixels of a word
    beats.delete();
    pix(8'hA1, 1'b0, 1'b0);
    pix(8'hA2, 1'b0, 1'b0);
    pix(8'hB1, 1'b1, 1'b0);
    pix(8'hB2, 1'b0, 1'b0);
    pix(8'hB3, 1'b0, 1'b0);
    pix(8'hB4, 1'b0, 1'b1);
    idle(5);
    chk("soferr_cnt", 64'(sof_err_cnt), 64'd1);
    chk("soferr_count", 64'(beats.size()), 64'd1);
    chk_beat("soferr_b0", 0, 1'b1, 1'b1, 4'hF, 32'hB4B3B2B1);
    chk("soferr_frames", 64'(frame_cnt), 64'd2);

    // One-pixel line with sof and eol
    beats.delete();
    pix(8'hC7, 1'b1, 1'b1);
    idle(5);
    chk_beat("one_b0", 0, 1'b1, 1'b1, 4'h1, 32'h000000C7);
    chk("one_frames", 64'(frame_cnt), 64'd3);
    chk("one_soferr", 64'(sof_err_cnt), 64'd1);

    // Overflow: 17 words into a 16-deep FIFO with TREADY low
    beats.delete();
    M_AXIS_TREADY = 1'b0;
    for (int k = 0; k < 17; k++)
      for (int i = 0; i < 4; i++) pix(8'((k << 2) | i), (k == 0) && (i == 0), 1'b0);
    idle(3);
    chk("ovf_set", 64'(ovf_sticky), 64'd1);
    chk("ovf_tvalid", 64'(M_AXIS_TVALID), 64'd1);
    for (int i = 0; i < 4; i++) pix(8'hEE, 1'b0, i == 3);
    idle(2);
    M_AXIS_TREADY = 1'b1;
    idle(22);
    chk("ovf_count", 64'(beats.size()), 64'd16);
    chk_beat("ovf_b0", 0, 1'b1, 1'b0, 4'hF, 32'h03020100);
    chk_beat("ovf_b7", 7, 1'b0, 1'b0, 4'hF, 32'h1F1E1D1C);
    chk_beat("ovf_b15", 15, 1'b0, 1'b0, 4'hF, 32'h3F3E3D3C);
    chk("ovf_frames", 64'(frame_cnt), 64'd4);
    pix(8'hD1, 1'b1, 1'b0);
    pix(8'hD2, 1'b0, 1'b0);
    pix(8'hD3, 1'b0, 1'b0);
    pix(8'hD4, 1'b0, 1'b1);
    idle(5);
    chk("resync_count", 64'(beats.size()), 64'd17);
    chk_beat("resync_b", 16, 1'b1, 1'b1, 4'hF, 32'hD4D3D2D1);
    chk("resync_frames", 64'(frame_cnt), 64'd5);
    chk("ovf_held", 64'(ovf_sticky), 64'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(ovf_sticky), 64'd0);

    // Full FIFO with pop and push in the same cycle
    beats.delete();
    M_AXIS_TREADY = 1'b0;
    for (int k = 0; k < 17; k++)
      for (int i = 0; i < 4; i++) pix(8'(8'h80 | (k << 2) | i), (k == 0) && (i == 0), 1'b0);
    chk("full_ovf_pre", 64'(ovf_sticky), 64'd0);
    M_AXIS_TREADY = 1'b1;
    idle(25);
    chk("full_ovf", 64'(ovf_sticky), 64'd0);
    chk("full_count", 64'(beats.size()), 64'd17);
    chk_beat("full_b0", 0, 1'b1, 1'b0, 4'hF, 32'h83828180);
    chk_beat("full_b15", 15, 1'b0, 1'b0, 4'hF, 32'hBFBEBDBC);
    chk_beat("full_b16", 16, 1'b0, 1'b0, 4'hF, 32'hC3C2C1C0);
    chk("full_frames", 64'(frame_cnt), 64'd6);

    // Reset with five beats buffered
    beats.delete();
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 20; i++) pix(8'(i), 1'b0, 1'b0);
    idle(2);
    chk("prerst_tvalid", 64'(M_AXIS_TVALID), 64'd1);
    M_AXIS_ARESET = 1'b1;
    step();
    chk("mrst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("mrst_tdata", 64'(M_AXIS_TDATA), 64'd0);
    chk("mrst_frames", 64'(frame_cnt), 64'd0);
    chk("mrst_ovf", 64'(ovf_sticky), 64'd0);
    chk("mrst_soferr", 64'(sof_err_cnt), 64'd0);
    M_AXIS_ARESET = 1'b0;
    M_AXIS_TREADY = 1'b1;
    idle(5);
    chk("mrst_discard", 64'(beats.size()), 64'd0);
    pix(8'h11, 1'b1, 1'b0);
    pix(8'h22, 1'b0, 1'b1);
    idle(5);
    chk_beat("mrst_b0", 0, 1'b1, 1'b1, 4'h3, 32'h00002211);
    chk("mrst_frames2", 64'(frame_cnt), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
